// File: rtl/oled_init_sequencer.sv
// oled_init_sequencer
//   Drives an SSD1306 OLED through an I2C master. A start request waits a
//   power-up delay and then sends the 25-byte init command list. Each refresh
//   then sends the 6-byte full-screen address window followed by 1024
//   frame-buffer bytes. Every byte is one master transaction. A NACK or a
//   timeout is retried up to RETRY_MAX times, after which the block faults.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   start, refresh    request pulses (power-up/init, one frame)
//   pix_addr/pix_data frame-buffer byte index / byte returned for it
//   m_*               I2C master transaction interface
//   init_done         init list completed
//   frame_busy        window or data phase in progress
//   frame_done        one-cycle pulse when the last data byte is acked
//   err               sticky fault flag, cleared by start

module oled_init_sequencer #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         PWRUP_WAIT = 50000,
    parameter int         RETRY_MAX  = 3,
    parameter int         TIMEOUT    = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       refresh,
    output logic [9:0] pix_addr,
    input  logic [7:0] pix_data,
    output logic       m_enable,
    output logic [6:0] m_slave_addr,
    output logic       m_read_write,
    output logic [7:0] m_control_frame,
    output logic [7:0] m_reg_addr,
    output logic [7:0] m_data_write,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_nack,
    output logic       init_done,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       err
);

    localparam int PW_W = (PWRUP_WAIT > 1) ? $clog2(PWRUP_WAIT) : 1;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW_W-1:0] PW_LAST    = PW_W'(PWRUP_WAIT - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [1:0]      RETRY_LAST = 2'(RETRY_MAX);
    localparam logic [4:0]      INIT_LAST  = 5'd24;
    localparam logic [4:0]      WIN_LAST   = 5'd5;

    typedef enum logic [3:0] {
        IDLE, PWRUP, INIT_ISSUE, INIT_WAIT, READY,
        WIN_ISSUE, WIN_WAIT, DATA_ISSUE, DATA_WAIT, FAULT
    } state_t;

    state_t          state_reg;
    state_t          retry_state;
    logic [4:0]      idx_reg;
    logic [1:0]      retry_reg;
    logic [PW_W-1:0] pw_cnt_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic            in_wait;
    logic            xfer_ok;
    logic            xfer_fail;

    function automatic logic [7:0] init_rom(input logic [4:0] i);
        case (i)
            5'd0:  init_rom = 8'hAE;  5'd1:  init_rom = 8'hD5;
            5'd2:  init_rom = 8'h80;  5'd3:  init_rom = 8'hA8;
            5'd4:  init_rom = 8'h3F;  5'd5:  init_rom = 8'hD3;
            5'd6:  init_rom = 8'h00;  5'd7:  init_rom = 8'h40;
            5'd8:  init_rom = 8'h8D;  5'd9:  init_rom = 8'h14;
            5'd10: init_rom = 8'h20;  5'd11: init_rom = 8'h00;
            5'd12: init_rom = 8'hA1;  5'd13: init_rom = 8'hC8;
            5'd14: init_rom = 8'hDA;  5'd15: init_rom = 8'h12;
            5'd16: init_rom = 8'h81;  5'd17: init_rom = 8'hCF;
            5'd18: init_rom = 8'hD9;  5'd19: init_rom = 8'hF1;
            5'd20: init_rom = 8'hDB;  5'd21: init_rom = 8'h40;
            5'd22: init_rom = 8'hA4;  5'd23: init_rom = 8'hA6;
            5'd24: init_rom = 8'hAF;
            default: init_rom = 8'h00;
        endcase
    endfunction

    // Column 0..127, page 0..7: the whole 128x64 panel.
    function automatic logic [7:0] win_rom(input logic [4:0] i);
        case (i)
            5'd0: win_rom = 8'h21;  5'd1: win_rom = 8'h00;
            5'd2: win_rom = 8'h7F;  5'd3: win_rom = 8'h22;
            5'd4: win_rom = 8'h00;  5'd5: win_rom = 8'h07;
            default: win_rom = 8'h00;
        endcase
    endfunction

    assign m_slave_addr = SLAVE_ADDR;
    assign m_read_write = 1'b0;

    always_comb begin
        in_wait   = (state_reg == INIT_WAIT) || (state_reg == WIN_WAIT) ||
                    (state_reg == DATA_WAIT);
        xfer_ok   = m_done && !m_nack;
        // A NACK and a timeout are handled identically.
        xfer_fail = (m_done && m_nack) || (!m_done && (to_cnt_reg == TO_LAST));
        case (state_reg)
            INIT_WAIT: retry_state = INIT_ISSUE;
            WIN_WAIT:  retry_state = WIN_ISSUE;
            default:   retry_state = DATA_ISSUE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            retry_reg       <= '0;
            pw_cnt_reg      <= '0;
            to_cnt_reg      <= '0;
            pix_addr        <= '0;
            m_enable        <= 1'b0;
            m_control_frame <= '0;
            m_reg_addr      <= '0;
            m_data_write    <= '0;
            init_done       <= 1'b0;
            frame_busy      <= 1'b0;
            frame_done      <= 1'b0;
            err             <= 1'b0;
        end else begin
            m_enable   <= 1'b0;
            frame_done <= 1'b0;

            case (state_reg)
                IDLE, FAULT: begin
                    if (start) begin
                        err        <= 1'b0;
                        pw_cnt_reg <= '0;
                        state_reg  <= PWRUP;
                    end
                end

                PWRUP: begin
                    if (pw_cnt_reg == PW_LAST) begin
                        idx_reg   <= '0;
                        retry_reg <= '0;
                        state_reg <= INIT_ISSUE;
                    end else begin
                        pw_cnt_reg <= pw_cnt_reg + 1'b1;
                    end
                end

                INIT_ISSUE, WIN_ISSUE, DATA_ISSUE: begin
                    // pix_addr only moves on a data ack, so pix_data has had
                    // at least one cycle to settle by the time it is sampled.
                    if (!m_busy) begin
                        m_control_frame <= (state_reg == DATA_ISSUE) ? 8'h40 : 8'h00;
                        m_reg_addr      <= (state_reg == INIT_ISSUE) ? init_rom(idx_reg)
                                                                     : win_rom(idx_reg);
                        m_data_write    <= pix_data;
                        m_enable        <= 1'b1;
                        to_cnt_reg      <= '0;
                        case (state_reg)
                            INIT_ISSUE: state_reg <= INIT_WAIT;
                            WIN_ISSUE:  state_reg <= WIN_WAIT;
                            default:    state_reg <= DATA_WAIT;
                        endcase
                    end
                end

                INIT_WAIT: begin
                    if (xfer_ok) begin
                        retry_reg <= '0;
                        if (idx_reg == INIT_LAST) begin
                            idx_reg   <= '0;
                            init_done <= 1'b1;
                            state_reg <= READY;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= INIT_ISSUE;
                        end
                    end else if (!xfer_fail) begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                READY: begin
                    // start is ignored here, so refresh wins by construction.
                    if (refresh) begin
                        frame_busy <= 1'b1;
                        idx_reg    <= '0;
                        retry_reg  <= '0;
                        state_reg  <= WIN_ISSUE;
                    end
                end

                WIN_WAIT: begin
                    if (xfer_ok) begin
                        retry_reg <= '0;
                        if (idx_reg == WIN_LAST) begin
                            idx_reg   <= '0;
                            pix_addr  <= '0;
                            state_reg <= DATA_ISSUE;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= WIN_ISSUE;
                        end
                    end else if (!xfer_fail) begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                DATA_WAIT: begin
                    if (xfer_ok) begin
                        retry_reg <= '0;
                        pix_addr  <= pix_addr + 1'b1;   // 1023 wraps to 0
                        if (pix_addr == 10'd1023) begin
                            frame_busy <= 1'b0;
                            frame_done <= 1'b1;
                            state_reg  <= READY;
                        end else begin
                            state_reg <= DATA_ISSUE;
                        end
                    end else if (!xfer_fail) begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                default: state_reg <= IDLE;
            endcase

            // Shared failure path for all three WAIT states; overrides the
            // state chosen above.
            if (in_wait && xfer_fail) begin
                if (retry_reg < RETRY_LAST) begin
                    retry_reg <= retry_reg + 1'b1;
                    state_reg <= retry_state;
                end else begin
                    retry_reg  <= '0;
                    err        <= 1'b1;
                    init_done  <= 1'b0;
                    frame_busy <= 1'b0;
                    state_reg  <= FAULT;
                end
            end
        end
    end

endmodule

// File: tb/tb_oled_init_sequencer.sv
// tb_oled_init_sequencer
//   Randomized bench for oled_init_sequencer. A behavioural I2C master
//   answers each enable after a random latency and can NACK or swallow
//   chosen bytes. A reference model tracks where the byte stream should be
//   (phase, position, attempt count) and predicts every transaction.

module tb_oled_init_sequencer;

    localparam int PW = 8;
    localparam int TO = 64;
    localparam int RM = 3;

    localparam int P_NONE  = 0;
    localparam int P_INIT  = 1;
    localparam int P_WIN   = 2;
    localparam int P_DATA  = 3;
    localparam int P_FAULT = 4;
    localparam int P_READY = 5;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       refresh = 1'b0;
    logic [9:0] pix_addr;
    logic [7:0] pix_data;
    logic       m_enable;
    logic [6:0] m_slave_addr;
    logic       m_read_write;
    logic [7:0] m_control_frame;
    logic [7:0] m_reg_addr;
    logic [7:0] m_data_write;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_nack = 1'b0;
    logic       init_done;
    logic       frame_busy;
    logic       frame_done;
    logic       err;

    logic [7:0] fb [1024];
    logic [7:0] init_seq [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
                                  8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8,
                                  8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB,
                                  8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] win_seq [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    assign pix_data = fb[pix_addr];

    oled_init_sequencer #(
        .SLAVE_ADDR(7'h3C), .PWRUP_WAIT(PW), .RETRY_MAX(RM), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .refresh(refresh),
        .pix_addr(pix_addr), .pix_data(pix_data),
        .m_enable(m_enable), .m_slave_addr(m_slave_addr),
        .m_read_write(m_read_write), .m_control_frame(m_control_frame),
        .m_reg_addr(m_reg_addr), .m_data_write(m_data_write),
        .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
        .init_done(init_done), .frame_busy(frame_busy),
        .frame_done(frame_done), .err(err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int ph = P_NONE, pos = 0, tries = 0;
    int exp_frames = 0, frame_pulses = 0;
    int cyc = 0, n_en = 0;
    int start_cyc = 0, first_en_cyc = 0, last_en_cyc = 0;
    bit first_en_pending = 1'b0;
    bit timed_out = 1'b0, retry_gap_seen = 1'b0;

    // master fault-injection policy
    int nack_ph = -1, nack_pos = 0, nack_left = 0;
    int wh_ph = -1, wh_pos = 0, wh_left = 0;
    int hit_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (frame_done) frame_pulses++;

    // Advance the model after a transaction outcome.
    task automatic outcome(input bit ok);
        if (ok) begin
            tries = 0;
            pos++;
            if (ph == P_INIT && pos == 25) ph = P_READY;
            else if (ph == P_WIN && pos == 6) begin ph = P_DATA; pos = 0; end
            else if (ph == P_DATA && pos == 1024) begin ph = P_READY; exp_frames++; end
        end else begin
            tries++;
            if (tries > RM) ph = P_FAULT;
        end
    endtask

    task automatic on_enable();
        logic [15:0] exp_w, got_w;
        int gap;
        n_en++;
        if (first_en_pending) begin first_en_cyc = cyc; first_en_pending = 1'b0; end
        $display("tx %0d cyc=%0d ph=%0d pos=%0d try=%0d ctrl=%02h reg=%02h data=%02h pix=%0d",
                 n_en, cyc, ph, pos, tries, m_control_frame, m_reg_addr, m_data_write, pix_addr);
        if (ph == P_INIT || ph == P_WIN || ph == P_DATA) begin
            if (ph == P_INIT) begin
                exp_w = {8'h00, init_seq[pos]};
                got_w = {m_control_frame, m_reg_addr};
                check_val("init_byte", 32'(got_w), 32'(exp_w));
            end else if (ph == P_WIN) begin
                exp_w = {8'h00, win_seq[pos]};
                got_w = {m_control_frame, m_reg_addr};
                check_val("win_byte", 32'(got_w), 32'(exp_w));
            end else begin
                exp_w = {8'h40, fb[pos]};
                got_w = {m_control_frame, m_data_write};
                check_val("data_byte", 32'(got_w), 32'(exp_w));
                check_val("pix_addr", 32'(pix_addr), 32'(pos));
            end
            check_val("slave_addr", 32'({m_read_write, m_slave_addr}), 32'h3C);
            if (ph == nack_ph && pos == nack_pos) hit_cnt++;
            if (timed_out) begin
                gap = cyc - last_en_cyc;
                check_val("retry_gap_in_range", 32'(gap >= TO && gap <= TO + 2), 32'd1);
                timed_out = 1'b0;
                retry_gap_seen = 1'b1;
            end
        end else begin
            check_val("enable_outside_sequence", 32'(m_enable), 32'd0);
        end
        last_en_cyc = cyc;
    endtask

    // Behavioural I2C master.
    initial begin
        int cnt;
        bit wh, nk;
        cnt = 0; wh = 1'b0; nk = 1'b0;
        forever begin
            @(negedge CLK);
            m_done = 1'b0;
            m_nack = 1'b0;
            if (RST) begin
                m_busy = 1'b0;
                cnt = 0;
            end else if (m_enable) begin
                on_enable();
                cnt = $urandom_range(2, 12);
                m_busy = 1'b1;
                wh = (ph == wh_ph && pos == wh_pos && wh_left > 0);
                if (wh) wh_left--;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    m_busy = 1'b0;
                    if (wh) begin
                        // transaction lost: no m_done, the DUT must time out
                        outcome(1'b0);
                        timed_out = 1'b1;
                    end else begin
                        nk = (ph == nack_ph && pos == nack_pos && nack_left > 0);
                        if (nk) nack_left--;
                        m_done = 1'b1;
                        m_nack = nk;
                        outcome(!nk);
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        if (ph == P_NONE || ph == P_FAULT) begin
            ph = P_INIT; pos = 0; tries = 0;
            start_cyc = cyc; first_en_pending = 1'b1;
        end
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic pulse_refresh();
        @(negedge CLK);
        refresh = 1'b1;
        if (ph == P_READY) begin ph = P_WIN; pos = 0; tries = 0; end
        @(negedge CLK);
        refresh = 1'b0;
    endtask

    task automatic wait_ph(input int target, input string tag, input int budget);
        int n;
        n = 0;
        while (ph != target && n < budget) begin @(posedge CLK); n++; end
        #1;
        if (ph != target) check_val({"timeout_", tag}, 32'(ph), 32'(target));
    endtask

    task automatic wait_data_pos(input int target, input bit need_en, input int budget);
        int n;
        n = 0;
        while (!(ph == P_DATA && pos >= target && (!need_en || m_enable)) && n < budget) begin
            @(posedge CLK); #1; n++;
        end
        if (n >= budget) check_val("timeout_data_pos", 32'(pos), 32'(target));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        for (int i = 0; i < 1024; i++) fb[i] = 8'($urandom);

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_m_enable", 32'(m_enable), 32'd0);
        check_val("rst_init_done", 32'(init_done), 32'd0);
        check_val("rst_frame_busy", 32'(frame_busy), 32'd0);
        check_val("rst_frame_done", 32'(frame_done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_pix_addr", 32'(pix_addr), 32'd0);
        check_val("rst_slave_addr", 32'(m_slave_addr), 32'h3C);
        check_val("rst_ctrl", 32'({m_control_frame, m_reg_addr, m_data_write}), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // refresh before init is ignored
        pulse_refresh();
        repeat (5) @(posedge CLK);
        #1;
        check_val("refresh_idle_ignored", 32'(frame_busy | m_enable), 32'd0);

        // clean init
        pulse_start();
        wait_ph(P_READY, "init1", 4000);
        check_val("init_done_after_last_ack", 32'(init_done), 32'd1);
        check_val("init1_err", 32'(err), 32'd0);
        check_val("init1_enables", 32'(n_en), 32'd25);
        check_val("pwrup_gap_ok", 32'((first_en_cyc - start_cyc) >= PW), 32'd1);

        // full frame
        pulse_refresh();
        check_val("frame_busy_set", 32'(frame_busy), 32'd1);
        n0 = n_en;
        wait_ph(P_READY, "frame1", 30000);
        check_val("frame1_done_pulse", 32'(frame_done), 32'd1);
        check_val("frame1_busy_clear", 32'(frame_busy), 32'd0);
        check_val("frame1_pix_wrap", 32'(pix_addr), 32'd0);
        check_val("frame1_enables", 32'(n_en - n0), 32'd1030);
        @(posedge CLK); #1;
        check_val("frame1_done_single", 32'(frame_done), 32'd0);

        // frame with a lost data byte and a refresh mid-frame
        for (int i = 0; i < 1024; i++) fb[i] = 8'($urandom);
        wh_ph = P_DATA; wh_pos = $urandom_range(100, 900); wh_left = 1;
        pulse_refresh();
        wait_data_pos(950, 1'b0, 30000);
        pulse_refresh();
        check_val("midframe_busy", 32'(frame_busy), 32'd1);
        wait_ph(P_READY, "frame2", 30000);
        repeat (20) @(posedge CLK); #1;
        check_val("frame_pulse_count", 32'(frame_pulses), 32'(exp_frames));
        check_val("timeout_retry_seen", 32'(retry_gap_seen), 32'd1);
        check_val("frame2_idle", 32'(frame_busy), 32'd0);
        wh_ph = -1;

        // persistent NACK on window byte 0 -> fault
        nack_ph = P_WIN; nack_pos = 0; nack_left = 100; hit_cnt = 0;
        pulse_refresh();
        wait_ph(P_FAULT, "fault", 2000);
        check_val("fault_err", 32'(err), 32'd1);
        check_val("fault_init_done", 32'(init_done), 32'd0);
        check_val("fault_frame_busy", 32'(frame_busy), 32'd0);
        check_val("fault_win_attempts", 32'(hit_cnt), 32'd4);
        n0 = n_en;
        pulse_refresh();
        repeat (200) @(posedge CLK); #1;
        check_val("fault_no_enables", 32'(n_en), 32'(n0));

        // restart from fault with two NACKs on init byte 3
        nack_ph = P_INIT; nack_pos = 3; nack_left = 2; hit_cnt = 0;
        pulse_start();
        #1;
        check_val("restart_err_clear", 32'(err), 32'd0);
        wait_ph(P_READY, "init2", 4000);
        check_val("init2_a8_attempts", 32'(hit_cnt), 32'd3);
        check_val("init2_done", 32'(init_done), 32'd1);
        check_val("init2_err", 32'(err), 32'd0);
        nack_ph = -1;

        // asynchronous reset in the middle of a frame
        pulse_refresh();
        wait_data_pos(500, 1'b1, 30000);
        #2;
        RST = 1'b1;
        ph = P_NONE;
        #1;
        check_val("arst_m_enable", 32'(m_enable), 32'd0);
        check_val("arst_init_done", 32'(init_done), 32'd0);
        check_val("arst_frame_busy", 32'(frame_busy), 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        n0 = n_en;
        pulse_refresh();
        repeat (50) @(posedge CLK); #1;
        check_val("post_rst_refresh_ignored", 32'(n_en), 32'(n0));
        check_val("post_rst_frame_busy", 32'(frame_busy), 32'd0);
        pulse_start();
        wait_ph(P_READY, "init3", 4000);
        check_val("init3_done", 32'(init_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
